// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : sevenseg_scan_driver
// Time-multiplexed 8-digit common-anode seven-segment driver with a load-time
// shadow register, frame-synchronous update and per-slot anode dead time.
// Rev    : 1.0
// ============================================================================
module sevenseg_scan_driver #(
   parameter int CLK_FREQUENCY_HZ       = 100000000,
   parameter int REFRESH_FREQUENCY_HZ   = 1000,
   parameter int CNTR_WIDTH             = 32,
   parameter int DEAD_CYCLES            = 100,
   parameter int SIMULATE               = 0,
   parameter int SIMULATE_FREQUENCY_CNT = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [31:0] digits_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  blank_in,
   output logic        pending,
   output logic        frame_tick,
   output logic [7:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n
);

   localparam int c_TOP_INT  = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                               : (CLK_FREQUENCY_HZ / REFRESH_FREQUENCY_HZ) - 1;
   localparam int c_DEAD_INT = (SIMULATE != 0) ? 1 : DEAD_CYCLES;

   localparam logic [CNTR_WIDTH-1:0] c_TOP_CNT  = CNTR_WIDTH'(c_TOP_INT);
   localparam logic [CNTR_WIDTH-1:0] c_DEAD_CNT = CNTR_WIDTH'(c_DEAD_INT);
   localparam logic [2:0]            c_LAST_IDX = 3'd7;

   localparam logic [7:0] c_AN_OFF  = 8'hFF;
   localparam logic [6:0] c_SEG_OFF = 7'h7F;

   // slot timing
   logic [CNTR_WIDTH-1:0] r_cnt;
   logic [2:0]            r_idx;

   // shadow (written by load) and active (shown) display images
   logic [31:0] r_sh_digits;
   logic [7:0]  r_sh_dp;
   logic [7:0]  r_sh_blank;
   logic [31:0] r_act_digits;
   logic [7:0]  r_act_dp;
   logic [7:0]  r_act_blank;

   logic        r_pending;
   logic        r_frame_tick;
   logic [7:0]  r_an_n;
   logic [6:0]  r_seg_n;
   logic        r_dp_n;

   logic        w_tick;
   logic        w_frame;
   logic        w_dead;
   logic        w_dark;
   logic [3:0]  w_nibble;
   logic [6:0]  w_seg;
   logic [7:0]  w_an;

   assign w_tick   = (r_cnt == c_TOP_CNT);
   assign w_frame  = w_tick && (r_idx == c_LAST_IDX);
   assign w_dead   = (r_cnt < c_DEAD_CNT);
   assign w_dark   = w_dead || r_act_blank[r_idx];
   assign w_nibble = r_act_digits[{r_idx, 2'b00} +: 4];
   assign w_an     = ~(8'b0000_0001 << r_idx);

   always_comb begin
      w_seg = c_SEG_OFF;
      case (w_nibble)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         4'hF: w_seg = 7'h0E;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
         r_idx <= r_idx + 3'd1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A load coincident with a frame boundary lands in the shadow only; the
   // active image takes the pre-load shadow and pending remains set.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sh_digits  <= '0;
         r_sh_dp      <= '0;
         r_sh_blank   <= 8'hFF;
         r_act_digits <= '0;
         r_act_dp     <= '0;
         r_act_blank  <= 8'hFF;
         r_pending    <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_frame;
         if (w_frame) begin
            r_act_digits <= r_sh_digits;
            r_act_dp     <= r_sh_dp;
            r_act_blank  <= r_sh_blank;
         end
         if (load) begin
            r_sh_digits <= digits_in;
            r_sh_dp     <= dp_in;
            r_sh_blank  <= blank_in;
            r_pending   <= 1'b1;
         end else if (w_frame) begin
            r_pending   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_an_n  <= c_AN_OFF;
         r_seg_n <= c_SEG_OFF;
         r_dp_n  <= 1'b1;
      end else if (w_dark) begin
         r_an_n  <= c_AN_OFF;
         r_seg_n <= c_SEG_OFF;
         r_dp_n  <= 1'b1;
      end else begin
         r_an_n  <= w_an;
         r_seg_n <= w_seg;
         r_dp_n  <= ~r_act_dp[r_idx];
      end
   end

   assign pending    = r_pending;
   assign frame_tick = r_frame_tick;
   assign an_n       = r_an_n;
   assign seg_n      = r_seg_n;
   assign dp_n       = r_dp_n;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_sevenseg_scan_driver
// Directed loads; expected frames are queued and a monitor checks every clock.
// Rev    : 1.0
// ============================================================================
module tb_sevenseg_scan_driver;
   localparam int c_PERIOD = 6;
   localparam int c_FRAME  = 48;

   typedef struct {
      logic [31:0] digits;
      logic [7:0]  dp;
      logic [7:0]  blank;
      logic        pend;
   } frame_t;

   logic        clk;
   logic        reset_n;
   logic        load;
   logic [31:0] digits_in;
   logic [7:0]  dp_in;
   logic [7:0]  blank_in;
   logic        pending;
   logic        frame_tick;
   logic [7:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;

   int     n_checks = 0;
   int     n_fail   = 0;
   frame_t exp_q[$];
   frame_t cur;
   int     k          = 0;
   bit     have_frame = 0;
   bit     saw_rst    = 0;

   sevenseg_scan_driver #(
      .CLK_FREQUENCY_HZ      (100000000),
      .REFRESH_FREQUENCY_HZ  (1000),
      .CNTR_WIDTH            (32),
      .DEAD_CYCLES           (100),
      .SIMULATE              (1),
      .SIMULATE_FREQUENCY_CNT(5)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .blank_in  (blank_in),
      .pending   (pending),
      .frame_tick(frame_tick),
      .an_n      (an_n),
      .seg_n     (seg_n),
      .dp_n      (dp_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // k counts clocks since the frame boundary; output k reflects slot state k-1
   function automatic logic [15:0] expect_out(input frame_t f, input int kk);
      int         s;
      int         c;
      int         slot;
      logic [7:0] one;
      s    = kk - 1;
      c    = s % c_PERIOD;
      slot = s / c_PERIOD;
      if (c == 0 || f.blank[slot])
         return {8'hFF, 7'h7F, 1'b1};
      one = 8'h01 << slot;
      return {~one, seg_of(f.digits[slot*4 +: 4]), ~f.dp[slot]};
   endfunction

   always @(posedge clk) saw_rst <= !reset_n;

   always @(negedge clk) begin : mon
      logic [15:0] e;
      frame_t      nxt;
      if (saw_rst) begin
         check({an_n, seg_n, dp_n} === 16'hFFFF, "reset_outputs", {16'h0, an_n, seg_n, dp_n}, 32'h0000FFFF);
         check(pending === 1'b0 && frame_tick === 1'b0, "reset_flags", {30'h0, pending, frame_tick}, 32'h0);
         cur        = '{32'h0, 8'h00, 8'hFF, 1'b0};
         k          = 0;
         have_frame = 1;
      end else if (have_frame) begin
         k++;
         if (k <= c_FRAME) begin
            e = expect_out(cur, k);
            check({an_n, seg_n, dp_n} === e, "display", {16'h0, an_n, seg_n, dp_n}, {16'h0, e});
         end
         check(frame_tick === (k == c_FRAME), "frame_tick_timing", {31'h0, frame_tick}, {31'h0, k == c_FRAME});
         if (frame_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_frame", 32'h1, 32'h0);
            end else begin
               nxt = exp_q.pop_front();
               check(pending === nxt.pend, "pending_at_frame", {31'h0, pending}, {31'h0, nxt.pend});
               cur = nxt;
            end
            k = 0;
         end
      end
   end

   task automatic push(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b, input logic pd);
      exp_q.push_back('{d, p, b, pd});
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
      @(posedge clk);
      #1;
      load      = 1'b1;
      digits_in = d;
      dp_in     = p;
      blank_in  = b;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic wait_tick();
      bit got;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) got = 1;
      end
      check(got, "wait_frame_tick", {31'h0, got}, 32'h1);
   endtask

   initial begin
      reset_n   = 1'b0;
      load      = 1'b0;
      digits_in = '0;
      dp_in     = '0;
      blank_in  = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // 1: basic digits
      do_load(32'h76543210, 8'h00, 8'h00);
      push(32'h76543210, 8'h00, 8'h00, 1'b0);
      wait_tick();

      // 2: lower four digits blanked
      do_load(32'h76543210, 8'h00, 8'h0F);
      push(32'h76543210, 8'h00, 8'h0F, 1'b0);
      wait_tick();

      // 3: decimal point on digit 0
      do_load(32'h76543210, 8'h01, 8'h00);
      push(32'h76543210, 8'h01, 8'h00, 1'b0);
      wait_tick();

      // 4: shadow to zero, then load exactly on the boundary clock
      do_load(32'h00000000, 8'h00, 8'h00);
      push(32'h00000000, 8'h00, 8'h00, 1'b0);
      wait_tick();
      push(32'h00000000, 8'h00, 8'h00, 1'b1);
      push(32'hFFFFFFFF, 8'h00, 8'h00, 1'b0);
      repeat (c_FRAME - 1) @(posedge clk);
      #1;
      load      = 1'b1;
      digits_in = 32'hFFFFFFFF;
      dp_in     = 8'h00;
      blank_in  = 8'h00;
      @(posedge clk);
      #1 load = 1'b0;
      wait_tick();
      wait_tick();

      // 6: two loads in one frame, last wins
      do_load(32'h11111111, 8'h00, 8'h00);
      do_load(32'h22222222, 8'h00, 8'h00);
      push(32'h22222222, 8'h00, 8'h00, 1'b0);
      wait_tick();

      // remaining hex glyphs with mixed decimal points
      do_load(32'hFEDCBA98, 8'hA5, 8'h00);
      push(32'hFEDCBA98, 8'hA5, 8'h00, 1'b0);
      wait_tick();

      // 5: reset while slot 3 is lit; a load during reset must be ignored
      repeat (21) @(posedge clk);
      #1;
      reset_n   = 1'b0;
      load      = 1'b1;
      digits_in = 32'h88888888;
      dp_in     = 8'hFF;
      blank_in  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      load    = 1'b0;
      push(32'h00000000, 8'h00, 8'hFF, 1'b0);
      push(32'h00000000, 8'h00, 8'hFF, 1'b0);
      wait_tick();
      wait_tick();

      repeat (5) @(negedge clk);
      check(exp_q.size() == 0, "queue_drained", exp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
